// File: rtl/wb_mem_if_pkg.sv
// Shared definitions for wb_mem_if: FSM state encodings and the zero word.
package wb_mem_if_pkg;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StBusy      = 2'd1,
        StWaitStall = 2'd2
    } state_e;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/wb_mem_if.sv
// Pipeline-to-Wishbone memory bridge; one instance per instruction or data port.
// Optional bus timeout abort is enabled by defining WB_TIMEOUT_EN.
module wb_mem_if
    import wb_mem_if_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        stall_req_o,
    output logic        bus_err_o,
    output logic [31:0] wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_data_i,
    input  logic        wb_ack_i
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        cyc_q, cyc_d;
    logic [31:0] rd_buf_q, rd_buf_d;
    logic        timeout;

`ifdef WB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q;

    // A flush or a real ack takes priority over the timeout abort.
    assign timeout   = (state_q == StBusy) && !flush_i && !wb_ack_i &&
                       (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    assign bus_err_o = timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (state_q == StBusy && state_d == StBusy) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign timeout    = 1'b0;
    assign bus_err_o  = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        sel_d       = sel_q;
        we_d        = we_q;
        cyc_d       = cyc_q;
        rd_buf_d    = rd_buf_q;
        cpu_data_o  = ZeroWord;
        stall_req_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                stall_req_o = cpu_ce_i & ~flush_i;
                if (cpu_ce_i && !flush_i) begin
                    addr_d  = cpu_addr_i;
                    wdata_d = cpu_data_i;
                    sel_d   = cpu_sel_i;
                    we_d    = cpu_we_i;
                    cyc_d   = 1'b1;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (flush_i) begin
                    addr_d  = ZeroWord;
                    wdata_d = ZeroWord;
                    sel_d   = 4'h0;
                    we_d    = 1'b0;
                    cyc_d   = 1'b0;
                    state_d = StIdle;
                end else if (wb_ack_i || timeout) begin
                    // A timeout completes like an ack carrying zero data.
                    cpu_data_o = wb_ack_i ? wb_data_i : ZeroWord;
                    rd_buf_d   = wb_ack_i ? wb_data_i : ZeroWord;
                    addr_d     = ZeroWord;
                    wdata_d    = ZeroWord;
                    sel_d      = 4'h0;
                    we_d       = 1'b0;
                    cyc_d      = 1'b0;
                    state_d    = stall_i ? StWaitStall : StIdle;
                end else begin
                    stall_req_o = 1'b1;
                end
            end
            StWaitStall: begin
                cpu_data_o = rd_buf_q;
                if (flush_i || !stall_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            addr_q   <= ZeroWord;
            wdata_q  <= ZeroWord;
            sel_q    <= 4'h0;
            we_q     <= 1'b0;
            cyc_q    <= 1'b0;
            rd_buf_q <= ZeroWord;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            cyc_q    <= cyc_d;
            rd_buf_q <= rd_buf_d;
        end
    end

    assign wb_addr_o = addr_q;
    assign wb_data_o = wdata_q;
    assign wb_sel_o  = sel_q;
    assign wb_we_o   = we_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;

endmodule

// File: tb/tb_wb_mem_if.sv
// Self-checking bench for wb_mem_if; expected read data flows through a scoreboard queue.
module tb_wb_mem_if;

    logic        clk;
    logic        rst;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        stall_i;
    logic        flush_i;
    logic        stall_req_o;
    logic        bus_err_o;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic [31:0] wb_data_i;
    logic        wb_ack_i;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    wb_mem_if #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_ce_i    (cpu_ce_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_sel_i   (cpu_sel_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_data_o  (cpu_data_o),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .stall_req_o (stall_req_o),
        .bus_err_o   (bus_err_o),
        .wb_addr_o   (wb_addr_o),
        .wb_data_o   (wb_data_o),
        .wb_sel_o    (wb_sel_o),
        .wb_we_o     (wb_we_o),
        .wb_stb_o    (wb_stb_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_data_i   (wb_data_i),
        .wb_ack_i    (wb_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                             input logic [31:0] data);
        cpu_ce_i   = 1'b1;
        cpu_we_i   = we;
        cpu_addr_i = addr;
        cpu_sel_i  = sel;
        cpu_data_i = data;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_we_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got cyc=%b stb=%b we=%b expected 0 0 0",
                     wb_cyc_o, wb_stb_o, wb_we_o);
        end
        n_tests++;
        if (wb_addr_o !== 32'h0 || wb_data_o !== 32'h0 || wb_sel_o !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got addr=%h data=%h sel=%h expected zeros",
                     wb_addr_o, wb_data_o, wb_sel_o);
        end
        n_tests++;
        if (cpu_data_o !== 32'h0 || stall_req_o !== 1'b0 || bus_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cpu: got data=%h stall=%b err=%b expected 0 0 0",
                     cpu_data_o, stall_req_o, bus_err_o);
        end
        rst = 1'b1;
    endtask

    task automatic test_read;
        tick;
        drive_req(1'b0, 32'h0000_0100, 4'hF, 32'h0);
        #1;
        n_tests++;
        if (stall_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL read_stall_accept: got %b expected 1", stall_req_o);
        end
        for (int i = 1; i < 3; i++) begin
            tick;
            #1;
            n_tests++;
            if (stall_req_o !== 1'b1 || wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1 ||
                wb_addr_o !== 32'h0000_0100 || wb_sel_o !== 4'hF || wb_we_o !== 1'b0) begin
                n_fail++;
                $display("FAIL read_busy_%0d: got stall=%b cyc=%b stb=%b addr=%h sel=%h we=%b expected 1 1 1 00000100 f 0",
                         i, stall_req_o, wb_cyc_o, wb_stb_o, wb_addr_o, wb_sel_o, wb_we_o);
            end
        end
        tick;
        wb_ack_i  = 1'b1;
        wb_data_i = 32'hDEAD_BEEF;
        exp_q.push_back(32'hDEAD_BEEF);
        #1;
        exp_v = exp_q.pop_front();
        n_tests++;
        if (cpu_data_o !== exp_v || stall_req_o !== 1'b0 || bus_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL read_ack: got data=%h stall=%b err=%b expected %h 0 0",
                     cpu_data_o, stall_req_o, bus_err_o, exp_v);
        end
        tick;
        wb_ack_i  = 1'b0;
        wb_data_i = 32'h0;
        cpu_ce_i  = 1'b0;
        #1;
        n_tests++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_addr_o !== 32'h0 ||
            cpu_data_o !== 32'h0) begin
            n_fail++;
            $display("FAIL read_after: got cyc=%b stb=%b addr=%h data=%h expected 0 0 0 0",
                     wb_cyc_o, wb_stb_o, wb_addr_o, cpu_data_o);
        end
    endtask

    task automatic test_write;
        tick;
        drive_req(1'b1, 32'h3000_0000, 4'h1, 32'h0000_0055);
        #1;
        n_tests++;
        if (stall_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL write_stall_accept: got %b expected 1", stall_req_o);
        end
        tick;
        wb_ack_i  = 1'b1;
        wb_data_i = 32'h0000_A5A5;
        exp_q.push_back(32'h0000_A5A5);
        #1;
        n_tests++;
        if (wb_cyc_o !== 1'b1 || wb_we_o !== 1'b1 || wb_sel_o !== 4'h1 ||
            wb_data_o !== 32'h0000_0055 || wb_addr_o !== 32'h3000_0000) begin
            n_fail++;
            $display("FAIL write_bus: got cyc=%b we=%b sel=%h data=%h addr=%h expected 1 1 1 00000055 30000000",
                     wb_cyc_o, wb_we_o, wb_sel_o, wb_data_o, wb_addr_o);
        end
        exp_v = exp_q.pop_front();
        n_tests++;
        if (stall_req_o !== 1'b0 || cpu_data_o !== exp_v) begin
            n_fail++;
            $display("FAIL write_ack: got stall=%b data=%h expected 0 %h",
                     stall_req_o, cpu_data_o, exp_v);
        end
        tick;
        wb_ack_i = 1'b0;
        cpu_ce_i = 1'b0;
        #1;
        n_tests++;
        if (wb_cyc_o !== 1'b0 || wb_we_o !== 1'b0 || wb_sel_o !== 4'h0 || wb_data_o !== 32'h0) begin
            n_fail++;
            $display("FAIL write_after: got cyc=%b we=%b sel=%h data=%h expected 0 0 0 0",
                     wb_cyc_o, wb_we_o, wb_sel_o, wb_data_o);
        end
    endtask

    task automatic test_back_to_back;
        tick;
        drive_req(1'b0, 32'h0000_0200, 4'hF, 32'h0);
        tick;
        wb_ack_i   = 1'b1;
        wb_data_i  = 32'h1111_1111;
        cpu_addr_i = 32'h0000_0204;
        exp_q.push_back(32'h1111_1111);
        #1;
        exp_v = exp_q.pop_front();
        n_tests++;
        if (cpu_data_o !== exp_v) begin
            n_fail++;
            $display("FAIL b2b_first: got %h expected %h", cpu_data_o, exp_v);
        end
        tick;
        wb_ack_i = 1'b0;
        #1;
        n_tests++;
        if (stall_req_o !== 1'b1 || wb_cyc_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: got stall=%b cyc=%b expected 1 0", stall_req_o, wb_cyc_o);
        end
        tick;
        wb_ack_i  = 1'b1;
        wb_data_i = 32'h2222_2222;
        exp_q.push_back(32'h2222_2222);
        #1;
        exp_v = exp_q.pop_front();
        n_tests++;
        if (wb_addr_o !== 32'h0000_0204 || wb_cyc_o !== 1'b1 || cpu_data_o !== exp_v) begin
            n_fail++;
            $display("FAIL b2b_second: got addr=%h cyc=%b data=%h expected 00000204 1 %h",
                     wb_addr_o, wb_cyc_o, cpu_data_o, exp_v);
        end
        tick;
        wb_ack_i = 1'b0;
        cpu_ce_i = 1'b0;
    endtask

    task automatic test_held_stall;
        tick;
        drive_req(1'b0, 32'h0000_0300, 4'hF, 32'h0);
        tick;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                wb_ack_i  = 1'b1;
                wb_data_i = 32'h1234_5678;
                stall_i   = 1'b1;
                cpu_ce_i  = 1'b0;
            end else begin
                wb_ack_i  = 1'b0;
                wb_data_i = 32'hFFFF_FFFF;
            end
            exp_q.push_back(32'h1234_5678);
            #1;
            exp_v = exp_q.pop_front();
            n_tests++;
            if (cpu_data_o !== exp_v || stall_req_o !== 1'b0) begin
                n_fail++;
                $display("FAIL held_stall_%0d: got data=%h stall=%b expected %h 0",
                         i, cpu_data_o, stall_req_o, exp_v);
            end
            tick;
        end
        stall_i = 1'b0;
        exp_q.push_back(32'h1234_5678);
        #1;
        exp_v = exp_q.pop_front();
        n_tests++;
        if (cpu_data_o !== exp_v) begin
            n_fail++;
            $display("FAIL held_release: got %h expected %h", cpu_data_o, exp_v);
        end
        tick;
        drive_req(1'b0, 32'h0000_0304, 4'hF, 32'h0);
        #1;
        n_tests++;
        if (stall_req_o !== 1'b1 || cpu_data_o !== 32'h0) begin
            n_fail++;
            $display("FAIL held_idle: got stall=%b data=%h expected 1 0", stall_req_o, cpu_data_o);
        end
        tick;
        wb_ack_i  = 1'b1;
        wb_data_i = 32'h0BAD_CAFE;
        exp_q.push_back(32'h0BAD_CAFE);
        #1;
        exp_v = exp_q.pop_front();
        n_tests++;
        if (cpu_data_o !== exp_v) begin
            n_fail++;
            $display("FAIL held_next: got %h expected %h", cpu_data_o, exp_v);
        end
        tick;
        wb_ack_i = 1'b0;
        cpu_ce_i = 1'b0;
    endtask

    task automatic test_flush_wait;
        tick;
        drive_req(1'b0, 32'h0000_0400, 4'hF, 32'h0);
        tick;
        wb_ack_i  = 1'b1;
        wb_data_i = 32'h0000_0077;
        stall_i   = 1'b1;
        cpu_ce_i  = 1'b0;
        tick;
        wb_ack_i = 1'b0;
        flush_i  = 1'b1;
        exp_q.push_back(32'h0000_0077);
        #1;
        exp_v = exp_q.pop_front();
        n_tests++;
        if (cpu_data_o !== exp_v) begin
            n_fail++;
            $display("FAIL flush_wait_data: got %h expected %h", cpu_data_o, exp_v);
        end
        tick;
        flush_i = 1'b0;
        drive_req(1'b0, 32'h0000_0404, 4'hF, 32'h0);
        #1;
        n_tests++;
        if (cpu_data_o !== 32'h0 || stall_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_wait_idle: got data=%h stall=%b expected 0 1",
                     cpu_data_o, stall_req_o);
        end
        tick;
        stall_i   = 1'b0;
        wb_ack_i  = 1'b1;
        wb_data_i = 32'h0000_0088;
        exp_q.push_back(32'h0000_0088);
        #1;
        exp_v = exp_q.pop_front();
        n_tests++;
        if (cpu_data_o !== exp_v) begin
            n_fail++;
            $display("FAIL flush_wait_next: got %h expected %h", cpu_data_o, exp_v);
        end
        tick;
        wb_ack_i = 1'b0;
        cpu_ce_i = 1'b0;
    endtask

    task automatic test_flush_busy;
        tick;
        drive_req(1'b1, 32'h0000_0500, 4'h3, 32'h0000_ABCD);
        tick;
        #1;
        n_tests++;
        if (stall_req_o !== 1'b1 || wb_cyc_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_busy_c1: got stall=%b cyc=%b expected 1 1", stall_req_o, wb_cyc_o);
        end
        tick;
        flush_i   = 1'b1;
        wb_ack_i  = 1'b1;
        wb_data_i = 32'hCAFE_F00D;
        exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front();
        n_tests++;
        if (cpu_data_o !== exp_v || stall_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_busy_c2: got data=%h stall=%b expected %h 0",
                     cpu_data_o, stall_req_o, exp_v);
        end
        tick;
        flush_i  = 1'b0;
        wb_ack_i = 1'b0;
        cpu_ce_i = 1'b0;
        #1;
        n_tests++;
        if (wb_cyc_o !== 1'b0 || wb_we_o !== 1'b0 || wb_addr_o !== 32'h0 ||
            wb_data_o !== 32'h0 || cpu_data_o !== 32'h0 || stall_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_busy_after: got cyc=%b we=%b addr=%h wdata=%h data=%h stall=%b expected all 0",
                     wb_cyc_o, wb_we_o, wb_addr_o, wb_data_o, cpu_data_o, stall_req_o);
        end
    endtask

    task automatic test_reset_mid;
        tick;
        drive_req(1'b0, 32'h0000_0600, 4'hF, 32'h0);
        tick;
        #1;
        rst      = 1'b0;
        cpu_ce_i = 1'b0;
        #1;
        n_tests++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_addr_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got cyc=%b stb=%b addr=%h expected 0 0 0",
                     wb_cyc_o, wb_stb_o, wb_addr_o);
        end
        tick;
        tick;
        rst = 1'b1;
        #1;
        n_tests++;
        if (cpu_data_o !== 32'h0 || wb_cyc_o !== 1'b0 || stall_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_release: got data=%h cyc=%b stall=%b expected 0 0 0",
                     cpu_data_o, wb_cyc_o, stall_req_o);
        end
        test_read();
    endtask

    task automatic test_timeout;
        tick;
        drive_req(1'b0, 32'h0000_0700, 4'hF, 32'h0);
        tick;
        cpu_ce_i = 1'b0;
`ifdef WB_TIMEOUT_EN
        for (int c = 1; c < 16; c++) begin
            #1;
            n_tests++;
            if (bus_err_o !== 1'b0 || stall_req_o !== 1'b1) begin
                n_fail++;
                $display("FAIL timeout_wait_%0d: got err=%b stall=%b expected 0 1",
                         c, bus_err_o, stall_req_o);
            end
            tick;
        end
        exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front();
        n_tests++;
        if (bus_err_o !== 1'b1 || cpu_data_o !== exp_v || stall_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_abort: got err=%b data=%h stall=%b expected 1 %h 0",
                     bus_err_o, cpu_data_o, stall_req_o, exp_v);
        end
        tick;
        #1;
        n_tests++;
        if (bus_err_o !== 1'b0 || wb_cyc_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_after: got err=%b cyc=%b expected 0 0", bus_err_o, wb_cyc_o);
        end
`else
        // Without the timeout feature the bus cycle must stay open indefinitely.
        repeat (20) tick;
        #1;
        n_tests++;
        if (wb_cyc_o !== 1'b1 || stall_req_o !== 1'b1 || bus_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL no_timeout: got cyc=%b stall=%b err=%b expected 1 1 0",
                     wb_cyc_o, stall_req_o, bus_err_o);
        end
        tick;
        wb_ack_i  = 1'b1;
        wb_data_i = 32'h0000_5A5A;
        exp_q.push_back(32'h0000_5A5A);
        #1;
        exp_v = exp_q.pop_front();
        n_tests++;
        if (cpu_data_o !== exp_v) begin
            n_fail++;
            $display("FAIL no_timeout_ack: got %h expected %h", cpu_data_o, exp_v);
        end
        tick;
        wb_ack_i = 1'b0;
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got time limit expected summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b0;
        cpu_ce_i   = 1'b0;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0;
        cpu_sel_i  = 4'h0;
        cpu_data_i = 32'h0;
        stall_i    = 1'b0;
        flush_i    = 1'b0;
        wb_data_i  = 32'h0;
        wb_ack_i   = 1'b0;

        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_held_stall();
        test_flush_wait();
        test_flush_busy();
        test_reset_mid();
        test_timeout();

        n_tests++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
